// File: rtl/read_loader.sv
// Read batch supplier: header FIFO feeding the Queue's new-read port plus a
// 4-bit-per-base query RAM. Optional statistics counters under LOADER_STATS_EN.
module read_loader #(
    parameter int NUM_READS = 1024,
    parameter int READ_LEN  = 128,
    parameter int HDR_DEPTH = 16,
    parameter int QUERY_LAT = 3
) (
    input  logic        Clk_32UI,
    input  logic        reset,
    input  logic        load_start,
    input  logic        load_finish,
    input  logic        base_we,
    input  logic [9:0]  base_read_num,
    input  logic [6:0]  base_pos,
    input  logic [3:0]  base_val,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [9:0]  hdr_read_num,
    input  logic [63:0] hdr_ik_x0,
    input  logic [63:0] hdr_ik_x1,
    input  logic [63:0] hdr_ik_x2,
    input  logic [63:0] hdr_ik_info,
    input  logic [6:0]  hdr_forward_i,
    input  logic        new_read,
    output logic        new_read_valid,
    output logic [9:0]  new_read_num,
    output logic [63:0] new_ik_x0,
    output logic [63:0] new_ik_x1,
    output logic [63:0] new_ik_x2,
    output logic [63:0] new_ik_info,
    output logic [6:0]  new_forward_i,
    output logic        load_done,
    input  logic [7:0]  query_position_2RAM,
    input  logic [9:0]  query_read_num_2RAM,
    input  logic [5:0]  query_status_2RAM,
    output logic [7:0]  new_read_query_2Queue,
    output logic        underflow_err
`ifdef LOADER_STATS_EN
   ,output logic [31:0] stat_reads_issued,
    output logic [31:0] stat_queries
`endif
);

    localparam int AW        = $clog2(HDR_DEPTH);
    localparam int RAM_DEPTH = NUM_READS * READ_LEN;
    localparam int RAW       = $clog2(RAM_DEPTH);
    localparam logic [5:0] BUBBLE = 6'b110000;

    typedef enum logic [1:0] {IDLE, LOADING, DONE} state_e;

    state_e         state_q;
    logic           load_done_q;
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           underflow_q;
    logic           full, empty, push, pop;
    logic [AW-1:0]  wr_idx, rd_idx;

    logic [9:0]     fifo_num_q  [HDR_DEPTH];
    logic [63:0]    fifo_x0_q   [HDR_DEPTH];
    logic [63:0]    fifo_x1_q   [HDR_DEPTH];
    logic [63:0]    fifo_x2_q   [HDR_DEPTH];
    logic [63:0]    fifo_info_q [HDR_DEPTH];
    logic [6:0]     fifo_fwd_q  [HDR_DEPTH];

    logic [3:0]     ram_q  [RAM_DEPTH];
    logic [4:0]     pipe_q [QUERY_LAT];
    logic [7:0]     query_out_q;
    logic [RAW-1:0] ram_wr_addr, ram_rd_addr;
    logic           ram_we, query_ok;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A flush from load_start overrides any push/pop in the same cycle;
    // a pop in the same cycle frees the slot a push into a full FIFO needs.
    assign pop  = new_read && !empty && !load_start;
    assign push = hdr_valid && (!full || pop) && (state_q != IDLE) && !load_start;

    // Next pointer values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (load_start) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Batch FSM with registered load_done
    always_ff @(posedge Clk_32UI or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            load_done_q <= 1'b0;
        end else if (load_start) begin
            state_q     <= LOADING;
            load_done_q <= 1'b0;
        end else if (load_finish && state_q == LOADING) begin
            state_q     <= DONE;
            load_done_q <= 1'b1;
        end
    end

    // FIFO pointers and sticky underflow flag
    always_ff @(posedge Clk_32UI or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (new_read && empty) underflow_q <= 1'b1;
        end
    end

    // Header storage (contents need no reset; outputs are gated by valid)
    always_ff @(posedge Clk_32UI) begin
        if (push) begin
            fifo_num_q[wr_idx]  <= hdr_read_num;
            fifo_x0_q[wr_idx]   <= hdr_ik_x0;
            fifo_x1_q[wr_idx]   <= hdr_ik_x1;
            fifo_x2_q[wr_idx]   <= hdr_ik_x2;
            fifo_info_q[wr_idx] <= hdr_ik_info;
            fifo_fwd_q[wr_idx]  <= hdr_forward_i;
        end
    end

    assign hdr_ready      = !full;
    assign new_read_valid = !empty;
    assign new_read_num   = empty ? '0 : fifo_num_q[rd_idx];
    assign new_ik_x0      = empty ? '0 : fifo_x0_q[rd_idx];
    assign new_ik_x1      = empty ? '0 : fifo_x1_q[rd_idx];
    assign new_ik_x2      = empty ? '0 : fifo_x2_q[rd_idx];
    assign new_ik_info    = empty ? '0 : fifo_info_q[rd_idx];
    assign new_forward_i  = empty ? '0 : fifo_fwd_q[rd_idx];
    assign load_done      = load_done_q;
    assign underflow_err  = underflow_q;

    assign ram_we      = base_we && (state_q == LOADING);
    assign ram_wr_addr = RAW'({base_read_num, base_pos});
    assign ram_rd_addr = RAW'({query_read_num_2RAM, query_position_2RAM[6:0]});
    assign query_ok    = (query_status_2RAM != BUBBLE) &&
                         (32'(query_position_2RAM) < READ_LEN) &&
                         (32'(query_read_num_2RAM) < NUM_READS);

    // Base RAM and query delay line; a same-address write returns old data
    always_ff @(posedge Clk_32UI) begin
        if (ram_we) ram_q[ram_wr_addr] <= base_val;
        pipe_q[0] <= {query_ok, ram_q[ram_rd_addr]};
        for (int i = 1; i < QUERY_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end

    // Query result register, the only query stage that sees reset
    always_ff @(posedge Clk_32UI or posedge reset) begin
        if (reset)
            query_out_q <= 8'hFF;
        else if (pipe_q[QUERY_LAT-1][4])
            query_out_q <= {4'h0, pipe_q[QUERY_LAT-1][3:0]};
        else
            query_out_q <= 8'hFF;
    end

    assign new_read_query_2Queue = query_out_q;

`ifdef LOADER_STATS_EN
    // Saturating pop and non-bubble query counters, cleared per batch
    always_ff @(posedge Clk_32UI or posedge reset) begin
        if (reset) begin
            stat_reads_issued <= '0;
            stat_queries      <= '0;
        end else if (load_start) begin
            stat_reads_issued <= '0;
            stat_queries      <= '0;
        end else begin
            if (pop && stat_reads_issued != '1)
                stat_reads_issued <= stat_reads_issued + 1'b1;
            if (query_status_2RAM != BUBBLE && stat_queries != '1)
                stat_queries <= stat_queries + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_read_loader.sv
// Directed bench for read_loader: query vector table plus FIFO/FSM sequences.
module tb_read_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start, load_finish;
    logic        base_we;
    logic [9:0]  base_read_num;
    logic [6:0]  base_pos;
    logic [3:0]  base_val;
    logic        hdr_valid, hdr_ready;
    logic [9:0]  hdr_read_num;
    logic [63:0] hdr_ik_x0, hdr_ik_x1, hdr_ik_x2, hdr_ik_info;
    logic [6:0]  hdr_forward_i;
    logic        new_read, new_read_valid;
    logic [9:0]  new_read_num;
    logic [63:0] new_ik_x0, new_ik_x1, new_ik_x2, new_ik_info;
    logic [6:0]  new_forward_i;
    logic        load_done;
    logic [7:0]  q_pos;
    logic [9:0]  q_rn;
    logic [5:0]  q_st;
    logic [7:0]  q_out;
    logic        underflow_err;
`ifdef LOADER_STATS_EN
    logic [31:0] stat_reads_issued, stat_queries;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    read_loader dut (
        .Clk_32UI              (clk),
        .reset                 (reset),
        .load_start            (load_start),
        .load_finish           (load_finish),
        .base_we               (base_we),
        .base_read_num         (base_read_num),
        .base_pos              (base_pos),
        .base_val              (base_val),
        .hdr_valid             (hdr_valid),
        .hdr_ready             (hdr_ready),
        .hdr_read_num          (hdr_read_num),
        .hdr_ik_x0             (hdr_ik_x0),
        .hdr_ik_x1             (hdr_ik_x1),
        .hdr_ik_x2             (hdr_ik_x2),
        .hdr_ik_info           (hdr_ik_info),
        .hdr_forward_i         (hdr_forward_i),
        .new_read              (new_read),
        .new_read_valid        (new_read_valid),
        .new_read_num          (new_read_num),
        .new_ik_x0             (new_ik_x0),
        .new_ik_x1             (new_ik_x1),
        .new_ik_x2             (new_ik_x2),
        .new_ik_info           (new_ik_info),
        .new_forward_i         (new_forward_i),
        .load_done             (load_done),
        .query_position_2RAM   (q_pos),
        .query_read_num_2RAM   (q_rn),
        .query_status_2RAM     (q_st),
        .new_read_query_2Queue (q_out),
        .underflow_err         (underflow_err)
`ifdef LOADER_STATS_EN
       ,.stat_reads_issued     (stat_reads_issued),
        .stat_queries          (stat_queries)
`endif
    );

    typedef struct {
        logic [7:0] pos;
        logic [9:0] rn;
        logic [5:0] st;
        logic [7:0] exp;
    } qvec_t;

    qvec_t vt[8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_hdr(input logic [9:0] rn);
        hdr_valid     = 1'b1;
        hdr_read_num  = rn;
        hdr_ik_x0     = 64'hA000_0000_0000_0000 | 64'(rn);
        hdr_ik_x1     = 64'hB000_0000_0000_0000 | 64'(rn);
        hdr_ik_x2     = 64'hC000_0000_0000_0000 | 64'(rn);
        hdr_ik_info   = 64'hD000_0000_0000_0000 | 64'(rn);
        hdr_forward_i = rn[6:0];
        step();
        hdr_valid     = 1'b0;
    endtask

    task automatic pop_one();
        new_read = 1'b1;
        step();
        new_read = 1'b0;
    endtask

    task automatic write_base(input logic [9:0] rn, input logic [6:0] pos,
                              input logic [3:0] val);
        base_we       = 1'b1;
        base_read_num = rn;
        base_pos      = pos;
        base_val      = val;
        step();
        base_we       = 1'b0;
    endtask

    // Query sampled at edge t; filler query afterwards would give FF if
    // latency were off by one.
    task automatic query_check(input string nm, input logic [7:0] pos,
                               input logic [9:0] rn, input logic [5:0] st,
                               input logic [7:0] exp);
        q_pos = pos;
        q_rn  = rn;
        q_st  = st;
        step();
        q_pos = 8'd200;
        q_st  = 6'd1;
        repeat (3) step();
        chk(nm, 64'(q_out), 64'(exp));
    endtask

    initial begin
        vt[0] = '{pos: 8'd3,   rn: 10'd5,    st: 6'd1,       exp: 8'h02};
        vt[1] = '{pos: 8'd0,   rn: 10'd0,    st: 6'd0,       exp: 8'h01};
        vt[2] = '{pos: 8'd127, rn: 10'd1023, st: 6'd2,       exp: 8'h03};
        vt[3] = '{pos: 8'd4,   rn: 10'd5,    st: 6'd1,       exp: 8'h04};
        vt[4] = '{pos: 8'd128, rn: 10'd5,    st: 6'd1,       exp: 8'hFF};
        vt[5] = '{pos: 8'd255, rn: 10'd0,    st: 6'd1,       exp: 8'hFF};
        vt[6] = '{pos: 8'd3,   rn: 10'd5,    st: 6'b110000,  exp: 8'hFF};
        vt[7] = '{pos: 8'd0,   rn: 10'd0,    st: 6'b110001,  exp: 8'h01};

        reset = 1'b1;
        load_start = 0; load_finish = 0; base_we = 0;
        base_read_num = 0; base_pos = 0; base_val = 0;
        hdr_valid = 0; hdr_read_num = 0;
        hdr_ik_x0 = 0; hdr_ik_x1 = 0; hdr_ik_x2 = 0; hdr_ik_info = 0;
        hdr_forward_i = 0; new_read = 0;
        q_pos = 0; q_rn = 0; q_st = 6'b110000;
        repeat (2) step();

        chk("rst_load_done", 64'(load_done), 0);
        chk("rst_hdr_ready", 64'(hdr_ready), 1);
        chk("rst_valid", 64'(new_read_valid), 0);
        chk("rst_num", 64'(new_read_num), 0);
        chk("rst_query", 64'(q_out), 64'hFF);
        chk("rst_underflow", 64'(underflow_err), 0);
        reset = 1'b0;
        step();

        // Batch load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        push_hdr(10'd7);
        push_hdr(10'd8);
        push_hdr(10'd9);
        write_base(10'd5, 7'd3, 4'd2);
        write_base(10'd0, 7'd0, 4'd1);
        write_base(10'd1023, 7'd127, 4'd3);
        write_base(10'd5, 7'd4, 4'd4);
        write_base(10'd6, 7'd6, 4'd1);

        // Same-cycle write and read of one address returns the old data
        base_we = 1'b1; base_read_num = 10'd6; base_pos = 7'd6; base_val = 4'd3;
        q_pos = 8'd6; q_rn = 10'd6; q_st = 6'd1;
        step();
        base_we = 1'b0;
        q_pos = 8'd200;
        repeat (3) step();
        chk("wr_rd_old", 64'(q_out), 64'h01);
        query_check("wr_rd_new", 8'd6, 10'd6, 6'd1, 8'h03);

        chk("pre_finish_done", 64'(load_done), 0);
        load_finish = 1'b1;
        step();
        load_finish = 1'b0;
        chk("load_done", 64'(load_done), 1);
        chk("hdr_valid_after", 64'(new_read_valid), 1);
        chk("head_num7", 64'(new_read_num), 7);
        chk("head_x0", new_ik_x0, 64'hA000_0000_0000_0007);
        chk("head_info", new_ik_info, 64'hD000_0000_0000_0007);
        chk("head_fwd", 64'(new_forward_i), 7);

        // Writes in DONE must not land
        write_base(10'd5, 7'd3, 4'd1);

        for (int i = 0; i < 8; i++)
            query_check($sformatf("qvec%0d", i), vt[i].pos, vt[i].rn,
                        vt[i].st, vt[i].exp);

        // Back-to-back queries return in order on consecutive cycles
        q_pos = 8'd3; q_rn = 10'd5; q_st = 6'd1;
        step();
        q_pos = 8'd127; q_rn = 10'd1023;
        step();
        q_pos = 8'd0; q_rn = 10'd0;
        step();
        q_pos = 8'd200;
        step();
        chk("b2b_0", 64'(q_out), 64'h02);
        step();
        chk("b2b_1", 64'(q_out), 64'h03);
        step();
        chk("b2b_2", 64'(q_out), 64'h01);

        // Drain initial headers
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drain%0d", i), 64'(new_read_num), 64'(7 + i));
            pop_one();
        end
        chk("drained_valid", 64'(new_read_valid), 0);

        // Fill to full across pointer wrap
        for (int i = 0; i < 16; i++) push_hdr(10'(100 + i));
        chk("full_ready", 64'(hdr_ready), 0);
        chk("full_head", 64'(new_read_num), 100);
        push_hdr(10'd200);
        hdr_valid = 1'b1; hdr_read_num = 10'd116;
        hdr_ik_x0 = 64'hA000_0000_0000_0074;
        hdr_forward_i = 7'd116;
        new_read = 1'b1;
        step();
        hdr_valid = 1'b0;
        new_read = 1'b0;
        chk("pp_still_full", 64'(hdr_ready), 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("order%0d", i), 64'(new_read_num), 64'(101 + i));
            pop_one();
        end
        chk("empty_valid", 64'(new_read_valid), 0);
        chk("empty_ready", 64'(hdr_ready), 1);

        // Underflow
        chk("no_underflow", 64'(underflow_err), 0);
        pop_one();
        chk("underflow_set", 64'(underflow_err), 1);
        chk("uf_valid", 64'(new_read_valid), 0);
        push_hdr(10'd300);
        chk("uf_ptr_valid", 64'(new_read_valid), 1);
        chk("uf_ptr_num", 64'(new_read_num), 300);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("restart_done", 64'(load_done), 0);
        chk("restart_flush", 64'(new_read_valid), 0);
        chk("underflow_sticky", 64'(underflow_err), 1);

        // Reset mid-LOADING with queued headers and a live query
        for (int i = 0; i < 5; i++) push_hdr(10'(400 + i));
        chk("five_head", 64'(new_read_num), 400);
        q_pos = 8'd3; q_rn = 10'd5; q_st = 6'd1;
        repeat (4) step();
        chk("live_query", 64'(q_out), 64'h02);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(new_read_valid), 0);
        chk("mid_rst_done", 64'(load_done), 0);
        chk("mid_rst_query", 64'(q_out), 64'hFF);
        chk("mid_rst_uf", 64'(underflow_err), 0);
        step();
        reset = 1'b0;
        q_st = 6'b110000;
        step();
        push_hdr(10'd500);
        chk("idle_push_ignored", 64'(new_read_valid), 0);
        load_finish = 1'b1;
        step();
        load_finish = 1'b0;
        step();
        chk("idle_finish_ignored", 64'(load_done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
